jtag_host_ctrl: RTL
===================

JTAG_HOST_CTRL -- requirements
Module: jtag_host_ctrl

Interface
REQ-001 SHALL have parameter MAXLEN, default 32, meaning the maximum shift length in bits; legal values are 2..32.
REQ-002 SHALL have port TCK, input, 1 bit: the single clock; all state changes on rising edge; the same TCK drives the TAP.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled on rising TCK.
REQ-005 SHALL have port is_dr, input, 1 bit: 1 = DR scan, 0 = IR scan; sampled with start.
REQ-006 SHALL have port len, input, 6 bits: number of bits to shift; sampled with start.
REQ-007 SHALL have port tdi_data, input, MAXLEN bits: scan-in data, shifted LSB first; sampled with start.
REQ-008 SHALL have port TDO, input, 1 bit: serial data from the TAP.
REQ-009 SHALL have port TMS, output, 1 bit: TAP mode select, registered.
REQ-010 SHALL have port TDI, output, 1 bit: serial data to the TAP, registered.
REQ-011 SHALL have port tdo_data, output, MAXLEN bits: captured scan-out, LSB = first bit.
REQ-012 SHALL have port busy, output, 1 bit: high while the reset sequence or a scan is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-015 SHALL launch TMS/TDI on rising edge k; the TAP samples them at rising edge k+1.
REQ-016 SHALL implement FSM states TLR_SEQ, IDLE, HDR, SHIFT, TAIL, DONE.
REQ-017 SHALL, in TLR_SEQ, drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle (TAP reaches Run-Test/Idle), then enter IDLE with busy=0.
REQ-018 SHALL, in IDLE, drive TMS=0 and TDI=0 and hold tdo_data from the last scan.
REQ-019 SHALL accept start in IDLE only when 1 <= len <= MAXLEN: latch is_dr, len and tdi_data; clear tdo_data; set busy on the same edge.
REQ-020 SHALL treat start in IDLE with len=0 or len>MAXLEN as rejected: pulse err for 1 cycle, no TMS activity, busy stays 0.
REQ-021 SHALL ignore start while busy, with no err.
REQ-022 SHALL, in HDR, launch TMS 1,0,0 for a DR scan or 1,1,0,0 for an IR scan, reaching Shift-DR/IR.
REQ-023 SHALL, in SHIFT, launch TDI=tdi_data[i] for i=0..len-1, with TMS=0 for i<len-1 and TMS=1 on i=len-1 (exit to Exit1).
REQ-024 SHALL drive TDI=0 outside SHIFT.
REQ-025 SHALL sample TDO into tdo_data[i] at the same rising edge on which the TAP samples TDI bit i.
REQ-026 SHALL leave tdo_data bits at index >= len at 0.
REQ-027 SHALL, in TAIL, launch TMS 1 (Update) then 0 (Run-Test/Idle).
REQ-028 SHALL, in DONE (the cycle after the final TMS=0 launch), pulse done for 1 cycle, drop busy, and return to IDLE.
REQ-029 SHALL have a total busy duration of 3+len+2 cycles for DR and 4+len+2 for IR, plus the DONE cycle.
REQ-030 SHALL use a bit counter of ceil(log2(MAXLEN))+1 bits with no wrap; len=1 places TMS=1 on the first shift bit.
REQ-031 SHALL give a simultaneous start and the done cycle no effect; start is honoured only from IDLE on a later edge.

Reset
REQ-032 SHALL, while RST=1, immediately force TMS=1, TDI=0, busy=1, done=0, err=0, tdo_data=0, and FSM=TLR_SEQ.
REQ-033 SHALL begin the REQ-017 sequence on the first rising TCK after RST deasserts.
REQ-034 SHALL abort any scan when RST asserts mid-scan: no done, latched request discarded, TAP recovered by the TLR sequence.

Verification
REQ-035 SHALL cover: RST pulse -> TMS=1 for 5 edges, then 0, busy=0 from the 7th edge; done never pulses.
REQ-036 SHALL cover: IR scan, len=5, tdi_data=0 -> TMS 1,1,0,0,0,0,0,0,1,1,0; TDI 0 throughout; done after 12 busy cycles.
REQ-037 SHALL cover: DR scan, len=18, tdi_data=0x252B6, with TDO modelled as TDI delayed 1 TCK (BYPASS) -> TDI bits 0,1,1,0,1,1,0,1,0,1,0,0,1,0,1,0,0,1; tdo_data=0x0A56C.
REQ-038 SHALL cover: start with len=0, then start with len=33 -> err pulses each time; TMS stays 0; busy stays 0.
REQ-039 SHALL cover: start pulsed mid DR scan -> ignored; the single done arrives at the original scan's end.
REQ-040 SHALL cover: RST asserted during SHIFT -> TMS=1 asynchronously, no done, then full TLR sequence and a subsequent len=1 DR scan -> TMS 1,0,0,1,1,0.

Source files
------------

// File: rtl/jtag_host_ctrl.sv
// JTAG host controller: TLR reset sequence, then IR/DR scans of 1..MAXLEN bits.
// TMS/TDI are launched on rising TCK; TDO is captured when the TAP samples TDI.
module jtag_host_ctrl #(
  parameter int MAXLEN = 32
) (
  input  logic              TCK,
  input  logic              RST,
  input  logic              start,
  input  logic              is_dr,
  input  logic [5:0]        len,
  input  logic [MAXLEN-1:0] tdi_data,
  input  logic              TDO,
  output logic              TMS,
  output logic              TDI,
  output logic [MAXLEN-1:0] tdo_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(MAXLEN) + 1;

  typedef enum logic [2:0] {
    TLR_SEQ, IDLE, HDR, SHIFT, TAIL, DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_seq;
  logic [CW-1:0]     r_bit;
  logic [CW-1:0]     r_cap_idx;
  logic              r_cap;
  logic              r_dr;
  logic [5:0]        r_len;
  logic [MAXLEN-1:0] r_data;
  logic [MAXLEN-1:0] r_tdo;
  logic              r_tms;
  logic              r_tdi;
  logic              r_err;

  logic w_req_ok;
  logic w_accept;
  logic w_last;
  logic w_hdr_end;
  logic w_tms_nxt;
  logic w_tdi_nxt;

  assign w_req_ok  = (len != 6'd0) &&
                     ({26'd0, len} <= 32'(MAXLEN));
  assign w_accept  = (r_state == IDLE) && start && w_req_ok;
  assign w_last    = ({{(32-CW){1'b0}}, r_bit} + 32'd1)
                     == {26'd0, r_len};
  assign w_hdr_end = r_dr ? (r_seq == 3'd2) : (r_seq == 3'd3);

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      r_state   <= TLR_SEQ;
      r_seq     <= '0;
      r_bit     <= '0;
      r_cap     <= 1'b0;
      r_cap_idx <= '0;
      r_dr      <= 1'b0;
      r_len     <= '0;
      r_data    <= '0;
      r_tdo     <= '0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tms     <= w_tms_nxt;
      r_tdi     <= w_tdi_nxt;
      r_seq     <= (w_state_nxt != r_state) ? 3'd0 : r_seq + 3'd1;
      r_bit     <= (r_state == SHIFT) ? r_bit + 1'b1 : '0;
      r_err     <= (r_state == IDLE) && start && !w_req_ok;
      r_cap     <= (r_state == SHIFT);
      r_cap_idx <= r_bit;
      if (w_accept) begin
        r_dr   <= is_dr;
        r_len  <= len;
        r_data <= tdi_data;
        r_tdo  <= '0;
      end else begin
        if (r_state == SHIFT)
          r_data <= r_data >> 1;
        // bit launched on the previous edge is sampled by the TAP now
        if (r_cap) begin
          for (int i = 0; i < MAXLEN; i++)
            if (r_cap_idx == CW'(i))
              r_tdo[i] <= TDO;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      TLR_SEQ: if (r_seq == 3'd6) w_state_nxt = IDLE;
      IDLE:    if (w_accept) w_state_nxt = HDR;
      HDR:     if (w_hdr_end) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = TAIL;
      TAIL:    if (r_seq == 3'd1) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = TLR_SEQ;
    endcase
  end

  always_comb begin
    w_tms_nxt = 1'b0;
    w_tdi_nxt = 1'b0;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    unique case (r_state)
      TLR_SEQ: w_tms_nxt = (r_seq < 3'd5);
      HDR:     w_tms_nxt = r_dr ? (r_seq == 3'd0)
                                : (r_seq <= 3'd1);
      SHIFT: begin
        w_tms_nxt = w_last;
        w_tdi_nxt = r_data[0];
      end
      TAIL:    w_tms_nxt = (r_seq == 3'd0);
      default: w_tms_nxt = 1'b0;
    endcase
  end

  assign TMS      = r_tms;
  assign TDI      = r_tdi;
  assign tdo_data = r_tdo;
  assign err      = r_err;

endmodule
